fetch_stage: RTL

Instruction-fetch stage of the pipelined 16-bit TSC CPU. It owns the PC, issues read requests to instruction memory over a ready-handshake interface, and fills the IF/ID pipeline register. The decode-stage control unit and ALU control consume its `opcode`/`func_code`. It honours stall requests from the hazard logic, PC redirects from jump/branch resolution, and a halt from HLT.

---
 rtl/fetch_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined 16-bit TSC CPU.
// Owns the PC, requests instruction words over a ready-handshake memory port and fills the
// IF/ID pipeline register. Honours stall, redirect and halt from later stages.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   i_read_m, i_address   instruction-memory read request and address
//   i_data, i_input_ready instruction word and its one-cycle response strobe
//   stall                 hold IF/ID, stop PC advance
//   redirect, redirect_pc take a new PC and flush IF/ID
//   halt                  stop fetching until reset
//   if_id_inst, if_id_pc_plus1, if_id_valid   IF/ID register
//   opcode, func_code     decoded fields of if_id_inst
//   fetch_count           instructions loaded into IF/ID (wraps)
module fetch_stage #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_read_m,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_input_ready,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] if_id_inst,
  output logic [WORD_SIZE-1:0] if_id_pc_plus1,
  output logic                 if_id_valid,
  output logic [3:0]           opcode,
  output logic [5:0]           func_code,
  output logic [15:0]          fetch_count
);

  typedef enum logic [1:0] {StFetch, StDiscard, StHold, StHalted} state_e;

  state_e                state_q, state_d;
  logic [WORD_SIZE-1:0]  pc_q, pc_d;
  logic [WORD_SIZE-1:0]  inst_q, inst_d;
  logic [WORD_SIZE-1:0]  pc1_q, pc1_d;
  logic                  valid_q, valid_d;
  logic [15:0]           count_q, count_d;
  logic [WORD_SIZE-1:0]  skid_q, skid_d;
  logic [WORD_SIZE-1:0]  target_q, target_d;
  logic [WORD_SIZE-1:0]  pc_inc;

  assign pc_inc = pc_q + WORD_SIZE'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pc1_d    = pc1_q;
    valid_d  = valid_q;
    count_d  = count_q;
    skid_d   = skid_q;
    target_d = target_q;
    if (halt) begin
      state_d = StHalted;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (i_input_ready) begin
            if (redirect) begin
              pc_d    = redirect_pc;
              valid_d = 1'b0;
            end else if (stall) begin
              // Response cannot enter IF/ID yet; park it and stop requesting.
              skid_d  = i_data;
              pc_d    = pc_inc;
              state_d = StHold;
            end else begin
              inst_d  = i_data;
              pc1_d   = pc_inc;
              valid_d = 1'b1;
              pc_d    = pc_inc;
              count_d = count_q + 16'd1;
            end
          end else if (redirect) begin
            // A request is in flight; its response must be consumed before retargeting.
            target_d = redirect_pc;
            valid_d  = 1'b0;
            state_d  = StDiscard;
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        StDiscard: begin
          if (redirect) target_d = redirect_pc;
          if (i_input_ready) begin
            pc_d    = redirect ? redirect_pc : target_q;
            state_d = StFetch;
          end
        end
        StHold: begin
          if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = StFetch;
          end else if (!stall) begin
            // PC already advanced past the parked word, so it is that word's pc_plus1.
            inst_d  = skid_q;
            pc1_d   = pc_q;
            valid_d = 1'b1;
            count_d = count_q + 16'd1;
            state_d = StFetch;
          end
        end
        StHalted: begin
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      pc1_q    <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      skid_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc1_q    <= pc1_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      skid_q   <= skid_d;
      target_q <= target_d;
    end
  end

  // In DISCARD the PC has not moved yet, so it is still the outstanding address.
  assign i_read_m       = reset_n && ((state_q == StFetch) || (state_q == StDiscard));
  assign i_address      = pc_q;
  assign if_id_inst     = inst_q;
  assign if_id_pc_plus1 = pc1_q;
  assign if_id_valid    = valid_q;
  assign opcode         = inst_q[WORD_SIZE-1 -: 4];
  assign func_code      = inst_q[5:0];
  assign fetch_count    = count_q;

endmodule
